// File: rtl/mem_stage_s4.sv
// Stage-4 data-memory access: load/store over a req/ack port, load lane align/extend, S4/S5 result.
// Latency 1 cycle for non-memory ops, >=2 for memory ops; stall_out holds upstream until ack or timeout.
module mem_stage_s4 #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic [6:0]  instr_flags_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic        out_valid,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_out,
    output logic [6:0]  instr_flags_out,
    output logic [2:0]  funct3_out,
    output logic        mem_exc_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           flushed_q, flushed_d;
    logic [1:0]     off_q, off_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic [4:0]     rd_q, rd_d;
    logic [6:0]     flags_q, flags_d;
    logic [2:0]     funct3_q, funct3_d;
    logic           mem_exc_q, mem_exc_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;

    logic           is_rd, is_wr, mem_op, f3_ok, misalign, exc;
    logic [1:0]     off;
    logic [3:0]     be_new;
    logic [31:0]    wdata_new, lane, load_val;
    logic           timeout_hit, done;

    assign is_rd  = instr_flags_in[1];
    assign is_wr  = instr_flags_in[2];
    assign mem_op = in_valid && (is_rd || is_wr);
    assign off    = alu_result_in[1:0];

    // Request decode: legality, alignment, lane enables and replicated store data
    always_comb begin
        f3_ok     = 1'b0;
        be_new    = 4'b1111;
        wdata_new = store_data_in;
        case (funct3_in)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !is_wr;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((funct3_in[1:0] == 2'b01) && off[0]) ||
                   ((funct3_in[1:0] == 2'b10) && (off != 2'b00));
        exc = mem_op && ((is_rd && is_wr) || !f3_ok || misalign);
        case (funct3_in[1:0])
            2'b00: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_new    = off[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_in[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data_in;
            end
        endcase
    end

    // Load lane select uses the offset captured at request time
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        off_d       = off_q;
        out_valid_d = 1'b0;
        wb_data_d   = wb_data_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        funct3_d    = funct3_q;
        mem_exc_d   = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        stall_out   = 1'b0;
        timeout_hit = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    rd_d     = rd_in;
                    funct3_d = funct3_in;
                    if (mem_op && !exc) begin
                        stall_out = 1'b1;
                        state_d   = REQ;
                        cnt_d     = '0;
                        flushed_d = 1'b0;
                        req_d     = 1'b1;
                        we_d      = is_wr;
                        addr_d    = {alu_result_in[31:2], 2'b00};
                        off_d     = off;
                        be_d      = be_new;
                        wdata_d   = wdata_new;
                        flags_d   = instr_flags_in;
                    end else begin
                        out_valid_d = 1'b1;
                        wb_data_d   = alu_result_in;
                        mem_exc_d   = exc;
                        flags_d     = {instr_flags_in[6:1], instr_flags_in[0] & !exc};
                    end
                end
            end
            REQ: begin
                timeout_hit = (ACK_TIMEOUT != 0) && !dmem_ack && (cnt_q == CNT_LAST);
                done        = dmem_ack || timeout_hit;
                stall_out   = !done;
                flushed_d   = flushed_q || flush;
                if (done) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (flushed_q || flush) begin
                        flags_d = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        mem_exc_d   = timeout_hit;
                        flags_d     = {flags_q[6:1], flags_q[0] & !we_q & !timeout_hit};
                        if (timeout_hit)
                            wb_data_d = '0;
                        else if (we_q)
                            wb_data_d = {addr_q[31:2], off_q};
                        else
                            wb_data_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            off_q       <= 2'b00;
            out_valid_q <= 1'b0;
            wb_data_q   <= '0;
            rd_q        <= '0;
            flags_q     <= '0;
            funct3_q    <= '0;
            mem_exc_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            off_q       <= off_d;
            out_valid_q <= out_valid_d;
            wb_data_q   <= wb_data_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            funct3_q    <= funct3_d;
            mem_exc_q   <= mem_exc_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign wb_data_out     = wb_data_q;
    assign rd_out          = rd_q;
    assign instr_flags_out = flags_q;
    assign funct3_out      = funct3_q;
    assign mem_exc_out     = mem_exc_q;
    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_stage_s4.sv
// Directed and random bench for mem_stage_s4 with ACK_TIMEOUT=4; expected values come from size/offset arithmetic.
module tb_mem_stage_s4;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] store_data_in = '0;
    logic [4:0]  rd_in = '0;
    logic [6:0]  instr_flags_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        stall_out, out_valid, mem_exc_out, dmem_req, dmem_we;
    logic [31:0] wb_data_out, dmem_addr, dmem_wdata;
    logic [4:0]  rd_out;
    logic [6:0]  instr_flags_out;
    logic [2:0]  funct3_out;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_stage_s4 #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .rd_in(rd_in),
        .instr_flags_in(instr_flags_in), .funct3_in(funct3_in), .stall_out(stall_out),
        .out_valid(out_valid), .wb_data_out(wb_data_out), .rd_out(rd_out),
        .instr_flags_out(instr_flags_out), .funct3_out(funct3_out), .mem_exc_out(mem_exc_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction end to end. ack_dly: REQ cycle index carrying the ack (>=TO means never).
    // fl_req_at: REQ cycle index with flush high (-1 none).
    task automatic do_op(input logic [6:0] fl, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] rd,
                         input int ack_dly, input bit fl_idle, input int fl_req_at);
        int size;
        bit uns, illegal, rd_op, wr_op, mem, exc, go, done, flushed, timed_out;
        logic [31:0] mask, ld, exp_wdata, exp_wb;
        logic [3:0]  exp_be;
        logic [6:0]  exp_fl;
        int k;
        rd_op = fl[1];
        wr_op = fl[2];
        mem   = rd_op || wr_op;
        uns   = 1'b0;
        illegal = 1'b0;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; illegal = wr_op; end
            3'd5: begin size = 2; uns = 1'b1; illegal = wr_op; end
            default: begin size = 1; illegal = 1'b1; end
        endcase
        exc = mem && ((rd_op && wr_op) || illegal || ((a % size) != 0));
        go  = mem && !exc && !fl_idle;
        exp_be = 4'(((1 << size) - 1) << (a % 4));
        if (size == 1)      exp_wdata = {24'h0, sd[7:0]} * 32'h01010101;
        else if (size == 2) exp_wdata = {16'h0, sd[15:0]} * 32'h00010001;
        else                exp_wdata = sd;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        ld = (rdat >> (8 * (a % 4))) & mask;
        if (!uns && size < 4 && ld[8 * size - 1]) ld = ld | ~mask;

        @(negedge clk);
        in_valid = 1'b1; instr_flags_in = fl; funct3_in = f3; alu_result_in = a;
        store_data_in = sd; rd_in = rd; flush = fl_idle;
        #1 chk("stall_accept", {31'h0, stall_out}, {31'h0, go});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        if (go) begin
            k = 0; done = 0; flushed = 0; timed_out = 0;
            while (!done) begin
                chk("req_held", {31'h0, dmem_req}, 32'h1);
                chk("dmem_addr", dmem_addr, a & ~32'h3);
                chk("dmem_be", {28'h0, dmem_be}, {28'h0, exp_be});
                chk("dmem_we", {31'h0, dmem_we}, {31'h0, wr_op});
                if (wr_op) chk("dmem_wdata", dmem_wdata, exp_wdata);
                dmem_ack = (k == ack_dly);
                dmem_rdata = rdat;
                flush = (k == fl_req_at);
                if (flush) flushed = 1;
                timed_out = !dmem_ack && (k == TO - 1);
                done = dmem_ack || timed_out;
                #1 chk("stall_req", {31'h0, stall_out}, {31'h0, !done});
                @(posedge clk);
                @(negedge clk);
                dmem_ack = 1'b0; flush = 1'b0;
                k++;
            end
            chk("req_drop", {31'h0, dmem_req}, 32'h0);
            chk("out_valid_mem", {31'h0, out_valid}, {31'h0, !flushed});
            if (flushed) begin
                chk("flags_flushed", {25'h0, instr_flags_out}, 32'h0);
            end else begin
                exp_wb = timed_out ? 32'h0 : (wr_op ? a : ld);
                exp_fl = (timed_out || wr_op) ? (fl & 7'h7E) : fl;
                chk("wb_mem", wb_data_out, exp_wb);
                chk("flags_mem", {25'h0, instr_flags_out}, {25'h0, exp_fl});
                chk("exc_mem", {31'h0, mem_exc_out}, {31'h0, timed_out});
                chk("rd_mem", {27'h0, rd_out}, {27'h0, rd});
                chk("f3_mem", {29'h0, funct3_out}, {29'h0, f3});
            end
        end else begin
            chk("req_none", {31'h0, dmem_req}, 32'h0);
            chk("out_valid_1c", {31'h0, out_valid}, {31'h0, !fl_idle});
            if (!fl_idle) begin
                exp_fl = exc ? (fl & 7'h7E) : fl;
                chk("wb_1c", wb_data_out, a);
                chk("flags_1c", {25'h0, instr_flags_out}, {25'h0, exp_fl});
                chk("exc_1c", {31'h0, mem_exc_out}, {31'h0, exc});
                chk("rd_1c", {27'h0, rd_out}, {27'h0, rd});
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_pulse", {31'h0, out_valid}, 32'h0);
        chk("exc_pulse", {31'h0, mem_exc_out}, 32'h0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_wb", wb_data_out, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(7'h01, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0, -1);                 // ALU
        do_op(7'h03, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 5'd6, 1, 0, -1);           // LB
        do_op(7'h03, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 5'd6, 1, 0, -1);           // LBU
        do_op(7'h05, 3'b001, 32'h202, 32'hABCD1234, 32'h0, 5'd0, 0, 0, -1);           // SH
        do_op(7'h03, 3'b010, 32'h101, 32'h0, 32'h0, 5'd7, 0, 0, -1);                  // misaligned LW
        do_op(7'h03, 3'b010, 32'h100, 32'h0, 32'h0, 5'd8, 99, 0, -1);                 // timeout
        do_op(7'h03, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 5'd9, 3, 0, 0);            // flush in REQ
        do_op(7'h01, 3'b000, 32'h4444, 32'h0, 32'h0, 5'd10, 0, 1, -1);                // flush in IDLE
        do_op(7'h07, 3'b010, 32'h400, 32'h0, 32'h0, 5'd11, 0, 0, -1);                 // read+write
        do_op(7'h05, 3'b101, 32'h404, 32'h0, 32'h0, 5'd12, 0, 0, -1);                 // SHU illegal

        // Late ack while idle is ignored
        @(negedge clk);
        dmem_ack = 1'b1;
        #1 chk("late_ack_stall", {31'h0, stall_out}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_valid", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        in_valid = 1'b1; instr_flags_in = 7'h03; funct3_in = 3'b010; alu_result_in = 32'h500;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_req", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1 chk("mid_rst_req", {31'h0, dmem_req}, 32'h0);
        chk("mid_rst_stall", {31'h0, stall_out}, 32'h0);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(7'h01, 3'b000, 32'hCAFE, 32'h0, 32'h0, 5'd13, 0, 0, -1);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] rf;
            logic [31:0] ra;
            int frq;
            rf = 7'($urandom);
            ra = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
            frq = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_op(rf, 3'($urandom_range(0, 7)), ra, $urandom, $urandom, 5'($urandom),
                  int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), frq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_s4.md
Name: mem_stage_s4

Overview:
- Stage-4 data-memory access unit of the 5-stage core.
- Consumes the execute-stage result, performs load/store over a req/ack data-memory port, and aligns/sign-extends load data.
- Presents the writeback value, rd, flags and funct3 to the S4/S5 pipeline latch.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 16: cycles to wait for dmem_ack before aborting with a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard the current instruction's result
- in_valid  in  1  instruction present on the inputs
- alu_result_in  in  32  effective address or ALU result
- store_data_in  in  32  rs2 value for stores
- rd_in  in  5  destination register
- instr_flags_in  in  7  [0]=reg_write, [1]=mem_read, [2]=mem_write, [6:3]=pass-through
- funct3_in  in  3  access size/sign
- stall_out  in→out  1  output; holds the upstream latch (drives its enable low)
- out_valid  out  1  one-cycle pulse: result valid for the S4/S5 latch
- wb_data_out  out  32  load data, or alu_result passthrough
- rd_out  out  5  registered rd
- instr_flags_out  out  7  registered flags; bit0 forced 0 on exception
- funct3_out  out  3  registered funct3
- mem_exc_out  out  1  pulses with out_valid on misalign, illegal funct3, or bus timeout
- dmem_req  out  1  request, held until ack
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete; rdata valid for loads
- dmem_rdata  in  32  read data

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; timeout counter 0.
- States: IDLE, REQ.
- A memory op is in_valid with mem_read or mem_write set.
- Legal funct3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- Exception cases, no dmem request issued:
  - mem_read and mem_write both set;
  - any other funct3 on a memory op;
  - H with addr[0]=1;
  - W with addr[1:0]≠0.
- IDLE, non-memory op or exception: result registered in 1 cycle; out_valid=1; wb_data_out=alu_result_in; stall_out=0. On exception, mem_exc_out=1 and instr_flags_out[0]=0.
- IDLE, legal memory op: stall_out=1 (combinational). At the clock edge, register dmem_addr/be/we/wdata, rd, flags and funct3; set dmem_req=1; go to REQ.
- Byte enables:
  - B: 1<<addr[1:0]
  - H: addr[1] ? 1100 : 0011
  - W: 1111
- Store data:
  - SB: {4{byte}}
  - SH: {2{half}}
  - SW: word
- REQ:
  - dmem_req and all dmem_* outputs held stable.
  - stall_out = !dmem_ack (upstream advances on the ack edge).
  - On dmem_ack: dmem_req=0; out_valid=1; state=IDLE.
  - Load: wb_data_out = lane selected by the registered addr[1:0], sign- or zero-extended per funct3.
  - Store: wb_data_out = address; instr_flags_out[0]=0.
- Latency: minimum 2 cycles for a memory op (ack in the first REQ cycle); 1 cycle for a non-memory op.
- Timeout: counter increments each REQ cycle without ack. When it reaches ACK_TIMEOUT, complete as if acked, except wb_data_out=0, mem_exc_out=1, flags[0]=0. A late ack arriving in IDLE is ignored.
- Flush:
  - In IDLE: out_valid=0 next cycle; no request issued; flush wins over in_valid.
  - In REQ: the bus transaction is never aborted. Stay in REQ until ack/timeout, then complete with out_valid=0 and flags output 0.
- out_valid=0 in every cycle without a completion; other outputs hold their last value.
- in_valid=0 in IDLE: no action; stall_out=0.

Test Plan:
- ALU op, alu_result_in=0x1234, rd=5, flags=0x01 → next cycle out_valid=1, wb_data_out=0x1234, rd_out=5, stall_out never 1.
- LB, addr=0x103, rdata=0x80FFFFFF, ack in 2nd REQ cycle → dmem_addr=0x100, be=1000, stall_out high 2 cycles; wb_data_out=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- SH, addr=0x202, store_data=0xABCD1234, immediate ack → dmem_we=1, be=1100, wdata=0x12341234, flags_out[0]=0, out_valid 2 cycles after accept.
- LW, addr=0x101 → no dmem_req; next cycle out_valid=1, mem_exc_out=1, flags_out[0]=0.
- LW, no ack, ACK_TIMEOUT=4 → req held 4 cycles, then out_valid=1, mem_exc_out=1, wb_data_out=0, req=0.
- Flush asserted during REQ, ack 3 cycles later → req held until ack, out_valid stays 0. Separately, rst_n dropped mid-REQ → dmem_req=0 immediately, state=IDLE.
